mem_access_unit: RTL and testbench

//  Initiator side of the data-memory interface: accepts one load/store request at a time

---
 rtl/mem_access_unit.sv | 187 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Initiator side of the data-memory interface. It takes one load/store at a
//   time from the MEM stage and produces the DM word address, byte enables and
//   write strobe. It returns sign/zero-extended load data, or an exception code
//   when the address is misaligned or out of range.
//
// Parameters
//   WAIT_CYCLES  extra wait cycles before the single DM access cycle (0..15)
//   ADDR_BITS    byte-address width of DM; any set bit above it is out of range
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_op                000 LW,001 LH,010 LHU,011 LB,100 LBU,101 SW,110 SH,111 SB
//   req_addr/wdata/pc     byte address, low-aligned store data, instruction PC
//   rsp_valid/rsp_ready   response handshake (response held until consumed)
//   rsp_data              extended load data; 0 for stores and exceptions
//   rsp_exc               00 ok, 01 misaligned, 10 out of range
//   dm_wr/dm_be           DM write strobe and byte enables (only during ACCESS)
//   dm_addr               DM word address (latched addr[13:2])
//   dm_wd                 DM write data (latched wdata, unshifted)
//   dm_result/dm_pc       latched byte address and PC, used for DM logging
//   dm_rd                 DM read word, combinational from dm_addr
module mem_access_unit #(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned ADDR_BITS   = 14
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_exc,
  output logic        dm_wr,
  output logic [3:0]  dm_be,
  output logic [11:0] dm_addr,
  output logic [31:0] dm_wd,
  output logic [31:0] dm_result,
  output logic [31:0] dm_pc,
  input  logic [31:0] dm_rd
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;
  typedef enum logic [2:0] {
    OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_SW, OP_SH, OP_SB
  } op_t;

  localparam logic [3:0] WAIT_INIT = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

  state_t      state_q;
  op_t         op_q;
  logic [31:0] addr_q, wdata_q, pc_q;
  logic [3:0]  cnt_q;
  logic        rsp_valid_q, dm_wr_q;
  logic [31:0] rsp_data_q;
  logic [1:0]  rsp_exc_q;
  logic [3:0]  dm_be_q;

  op_t         req_op_d;
  logic [1:0]  exc_d;
  op_t         acc_op_d;
  logic [1:0]  acc_lo_d;
  logic        wr_d;
  logic [3:0]  be_d;
  logic [15:0] half_d;
  logic [7:0]  byte_d;
  logic [31:0] ld_d;

  always_comb begin
    req_op_d = op_t'(req_op);

    // Misaligned takes priority over out of range.
    exc_d = 2'b00;
    if (((req_op_d == OP_LW || req_op_d == OP_SW) && req_addr[1:0] != 2'b00) ||
        ((req_op_d == OP_LH || req_op_d == OP_LHU || req_op_d == OP_SH) && req_addr[0]))
      exc_d = 2'b01;
    else if ((req_addr >> ADDR_BITS) != '0)
      exc_d = 2'b10;

    // Strobes are registered on entry to ACCESS. When WAIT is skipped, the
    // request fields have not been latched yet, so they come from the inputs.
    acc_op_d = (state_q == S_IDLE) ? req_op_d : op_q;
    acc_lo_d = (state_q == S_IDLE) ? req_addr[1:0] : addr_q[1:0];
    wr_d = 1'b0;
    be_d = '0;
    unique case (acc_op_d)
      OP_SW: begin wr_d = 1'b1; be_d = 4'b1111; end
      OP_SH: begin wr_d = 1'b1; be_d = acc_lo_d[1] ? 4'b1100 : 4'b0011; end
      OP_SB: begin wr_d = 1'b1; be_d = 4'b0001 << acc_lo_d; end
      default: ;
    endcase

    half_d = addr_q[1] ? dm_rd[31:16] : dm_rd[15:0];
    byte_d = 8'(dm_rd >> {addr_q[1:0], 3'b000});
    ld_d   = '0;
    unique case (op_q)
      OP_LW:  ld_d = dm_rd;
      OP_LH:  ld_d = {{16{half_d[15]}}, half_d};
      OP_LHU: ld_d = {16'h0000, half_d};
      OP_LB:  ld_d = {{24{byte_d[7]}}, byte_d};
      OP_LBU: ld_d = {24'h000000, byte_d};
      default: ld_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= OP_LW;
      addr_q      <= '0;
      wdata_q     <= '0;
      pc_q        <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_exc_q   <= '0;
      dm_wr_q     <= 1'b0;
      dm_be_q     <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            op_q    <= req_op_d;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            pc_q    <= req_pc;
            if (exc_d != 2'b00) begin
              rsp_exc_q   <= exc_d;
              rsp_data_q  <= '0;
              rsp_valid_q <= 1'b1;
              state_q     <= S_RESP;
            end else if (WAIT_CYCLES > 0) begin
              cnt_q   <= WAIT_INIT;
              state_q <= S_WAIT;
            end else begin
              dm_wr_q <= wr_d;
              dm_be_q <= be_d;
              state_q <= S_ACCESS;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            dm_wr_q <= wr_d;
            dm_be_q <= be_d;
            state_q <= S_ACCESS;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_ACCESS: begin
          dm_wr_q     <= 1'b0;
          dm_be_q     <= '0;
          rsp_exc_q   <= 2'b00;
          rsp_data_q  <= ld_d;
          rsp_valid_q <= 1'b1;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_exc   = rsp_exc_q;
  assign dm_wr     = dm_wr_q;
  assign dm_be     = dm_be_q;
  assign dm_addr   = addr_q[13:2];
  assign dm_wd     = wdata_q;
  assign dm_result = addr_q;
  assign dm_pc     = pc_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Unit A: no wait cycles.
  logic        a_req_valid = 1'b0, a_req_ready, a_rsp_valid, a_rsp_ready = 1'b1, a_dm_wr;
  logic [2:0]  a_req_op = '0;
  logic [31:0] a_req_addr = '0, a_req_wdata = '0, a_req_pc = '0, a_rsp_data;
  logic [1:0]  a_rsp_exc;
  logic [3:0]  a_dm_be;
  logic [11:0] a_dm_addr;
  logic [31:0] a_dm_wd, a_dm_result, a_dm_pc, a_dm_rd = '0;

  // Unit B: two wait cycles.
  logic        b_req_valid = 1'b0, b_req_ready, b_rsp_valid, b_rsp_ready = 1'b1, b_dm_wr;
  logic [2:0]  b_req_op = '0;
  logic [31:0] b_req_addr = '0, b_req_wdata = '0, b_req_pc = '0, b_rsp_data;
  logic [1:0]  b_rsp_exc;
  logic [3:0]  b_dm_be;
  logic [11:0] b_dm_addr;
  logic [31:0] b_dm_wd, b_dm_result, b_dm_pc, b_dm_rd = '0;

  mem_access_unit #(.WAIT_CYCLES(0), .ADDR_BITS(14)) dut_a (
    .clk(clk), .reset(reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_op(a_req_op),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_pc(a_req_pc),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_data(a_rsp_data),
    .rsp_exc(a_rsp_exc), .dm_wr(a_dm_wr), .dm_be(a_dm_be), .dm_addr(a_dm_addr),
    .dm_wd(a_dm_wd), .dm_result(a_dm_result), .dm_pc(a_dm_pc), .dm_rd(a_dm_rd)
  );

  mem_access_unit #(.WAIT_CYCLES(2), .ADDR_BITS(14)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_op(b_req_op),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_pc(b_req_pc),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data),
    .rsp_exc(b_rsp_exc), .dm_wr(b_dm_wr), .dm_be(b_dm_be), .dm_addr(b_dm_addr),
    .dm_wd(b_dm_wd), .dm_result(b_dm_result), .dm_pc(b_dm_pc), .dm_rd(b_dm_rd)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_send(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
    a_req_valid = 1'b1;
    a_req_op    = op;
    a_req_addr  = addr;
    a_req_wdata = wd;
    a_req_pc    = 32'h0000_1000 + addr;
    step();
    a_req_valid = 1'b0;
  endtask

  // Non-excepting access: one ACCESS cycle, then one RESP cycle (rsp_ready=1).
  task automatic a_mem(input string tag, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rd, input logic exp_wr,
                       input logic [3:0] exp_be, input logic [31:0] exp_data);
    a_dm_rd = rd;
    chk({tag, ".ready_idle"}, 32'(a_req_ready), 32'd1);
    a_send(op, addr, wd);
    chk({tag, ".wr"}, 32'(a_dm_wr), 32'(exp_wr));
    chk({tag, ".be"}, 32'(a_dm_be), 32'(exp_be));
    chk({tag, ".addr"}, 32'(a_dm_addr), 32'(addr[13:2]));
    chk({tag, ".wd"}, a_dm_wd, wd);
    chk({tag, ".ready_busy"}, 32'(a_req_ready), 32'd0);
    chk({tag, ".valid_early"}, 32'(a_rsp_valid), 32'd0);
    step();
    chk({tag, ".wr_off"}, 32'(a_dm_wr), 32'd0);
    chk({tag, ".be_off"}, 32'(a_dm_be), 32'd0);
    chk({tag, ".valid"}, 32'(a_rsp_valid), 32'd1);
    chk({tag, ".exc"}, 32'(a_rsp_exc), 32'd0);
    chk({tag, ".data"}, a_rsp_data, exp_data);
    chk({tag, ".result"}, a_dm_result, addr);
    chk({tag, ".pc"}, a_dm_pc, 32'h0000_1000 + addr);
    step();
    chk({tag, ".valid_done"}, 32'(a_rsp_valid), 32'd0);
    chk({tag, ".ready_done"}, 32'(a_req_ready), 32'd1);
  endtask

  // Excepting request: straight to RESP, no DM strobe.
  task automatic a_exc(input string tag, input logic [2:0] op, input logic [31:0] addr,
                       input logic [1:0] exp_exc);
    a_dm_rd = 32'hFFFF_FFFF;
    a_send(op, addr, 32'hCAFE_F00D);
    chk({tag, ".valid"}, 32'(a_rsp_valid), 32'd1);
    chk({tag, ".exc"}, 32'(a_rsp_exc), 32'(exp_exc));
    chk({tag, ".data"}, a_rsp_data, 32'd0);
    chk({tag, ".wr"}, 32'(a_dm_wr), 32'd0);
    chk({tag, ".be"}, 32'(a_dm_be), 32'd0);
    step();
    chk({tag, ".valid_done"}, 32'(a_rsp_valid), 32'd0);
    chk({tag, ".wr_after"}, 32'(a_dm_wr), 32'd0);
    chk({tag, ".ready_done"}, 32'(a_req_ready), 32'd1);
  endtask

  initial begin
    // Reset state
    step();
    step();
    chk("rst.ready", 32'(a_req_ready), 32'd1);
    chk("rst.valid", 32'(a_rsp_valid), 32'd0);
    chk("rst.data", a_rsp_data, 32'd0);
    chk("rst.exc", 32'(a_rsp_exc), 32'd0);
    chk("rst.wr", 32'(a_dm_wr), 32'd0);
    chk("rst.be", 32'(a_dm_be), 32'd0);
    chk("rst.addr", 32'(a_dm_addr), 32'd0);
    chk("rst.pc", a_dm_pc, 32'd0);
    chk("rst.b_ready", 32'(b_req_ready), 32'd1);
    reset = 1'b0;
    step();

    // Stores
    a_mem("sb6",  3'b111, 32'h0000_0006, 32'h1234_56AB, 32'h0, 1'b1, 4'b0100, 32'h0);
    a_mem("sh2",  3'b110, 32'h0000_0002, 32'h0000_BEEF, 32'h0, 1'b1, 4'b1100, 32'h0);
    a_mem("sh0",  3'b110, 32'h0000_0000, 32'h0000_1234, 32'h0, 1'b1, 4'b0011, 32'h0);
    a_mem("sw4",  3'b101, 32'h0000_0004, 32'hA5A5_5A5A, 32'h0, 1'b1, 4'b1111, 32'h0);
    // Loads
    a_mem("lb6",  3'b011, 32'h0000_0006, 32'h0, 32'h00AB_0000, 1'b0, 4'b0000, 32'hFFFF_FFAB);
    a_mem("lbu6", 3'b100, 32'h0000_0006, 32'h0, 32'h00AB_0000, 1'b0, 4'b0000, 32'h0000_00AB);
    a_mem("lhA",  3'b001, 32'h0000_000A, 32'h0, 32'h8001_FFFF, 1'b0, 4'b0000, 32'hFFFF_8001);
    a_mem("lhu2", 3'b010, 32'h0000_0002, 32'h0, 32'h8001_FFFF, 1'b0, 4'b0000, 32'h0000_8001);
    a_mem("lh0",  3'b001, 32'h0000_0000, 32'h0, 32'h8001_7FFF, 1'b0, 4'b0000, 32'h0000_7FFF);
    a_mem("lw8",  3'b000, 32'h0000_0008, 32'h0, 32'hDEAD_BEEF, 1'b0, 4'b0000, 32'hDEAD_BEEF);
    a_mem("lwtop", 3'b000, 32'h0000_3FFC, 32'h0, 32'h0BAD_F00D, 1'b0, 4'b0000, 32'h0BAD_F00D);
    // Exceptions
    a_exc("sh3",    3'b110, 32'h0000_0003, 2'b01);
    a_exc("lw4000", 3'b000, 32'h0000_4000, 2'b10);
    a_exc("lw4002", 3'b000, 32'h0000_4002, 2'b01);
    a_exc("lb_oor", 3'b011, 32'h8000_0001, 2'b10);

    // Unit B: SW with two wait cycles and a stalled response
    b_rsp_ready = 1'b0;
    b_req_valid = 1'b1; b_req_op = 3'b101; b_req_addr = 32'h10;
    b_req_wdata = 32'h0102_0304; b_req_pc = 32'h400;
    step();
    b_req_valid = 1'b0;
    chk("bw.wr_n0", 32'(b_dm_wr), 32'd0);
    chk("bw.ready_n0", 32'(b_req_ready), 32'd0);
    step();
    chk("bw.wr_n1", 32'(b_dm_wr), 32'd0);
    chk("bw.ready_n1", 32'(b_req_ready), 32'd0);
    step();
    chk("bw.wr_n2", 32'(b_dm_wr), 32'd1);
    chk("bw.be_n2", 32'(b_dm_be), 32'hF);
    chk("bw.addr_n2", 32'(b_dm_addr), 32'd4);
    chk("bw.wd_n2", b_dm_wd, 32'h0102_0304);
    chk("bw.valid_n2", 32'(b_rsp_valid), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bw.hold_valid", 32'(b_rsp_valid), 32'd1);
      chk("bw.hold_ready", 32'(b_req_ready), 32'd0);
      chk("bw.hold_wr", 32'(b_dm_wr), 32'd0);
      chk("bw.hold_exc", 32'(b_rsp_exc), 32'd0);
    end
    b_rsp_ready = 1'b1;
    step();
    chk("bw.valid_done", 32'(b_rsp_valid), 32'd0);
    chk("bw.ready_done", 32'(b_req_ready), 32'd1);

    // Unit B: reset during WAIT drops the store
    b_req_valid = 1'b1; b_req_op = 3'b101; b_req_addr = 32'h20;
    b_req_wdata = 32'h5555_AAAA; b_req_pc = 32'h404;
    step();
    b_req_valid = 1'b0;
    chk("br.in_wait", 32'(b_req_ready), 32'd0);
    reset = 1'b1;
    step();
    chk("br.wr_rst", 32'(b_dm_wr), 32'd0);
    chk("br.valid_rst", 32'(b_rsp_valid), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("br.wr_after", 32'(b_dm_wr), 32'd0);
      chk("br.valid_after", 32'(b_rsp_valid), 32'd0);
      chk("br.ready_after", 32'(b_req_ready), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
